mips_debug_ctrl: RTL and testbench

UART-driven debug controller between the UART RX/TX pair and the MIPS core. It loads a program byte-wise into instruction memory and runs the CPU either continuously or one step at a time. After a halt or a step, it streams a parametrised multi-word state dump (PC, registers, etc.) back over TX. It drives the core's reset and clock-enable so the CPU only advances under debug control.

---
 rtl/mips_debug_ctrl.sv | 122 ++++++++++++
 tb/tb_mips_debug_ctrl.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_debug_ctrl.sv
// mips_debug_ctrl: UART-driven program loader, run/step controller and state dumper for a MIPS core
module mips_debug_ctrl #(
  parameter int DATA_W = 8,
  parameter int INST_W = 32,
  parameter int IADDR_W = 10,
  parameter int DUMP_W = 32,
  parameter int DUMP_WORDS = 4,
  parameter logic [5:0] HALT_OP = 6'b111111,
  localparam int SEL_W = DUMP_WORDS > 1 ? $clog2(DUMP_WORDS) : 1
) (
  input  logic clk,
  input  logic reset,
  input  logic rx_done_tick,
  input  logic [DATA_W-1:0] rx_data,
  input  logic tx_done_tick,
  output logic tx_start,
  output logic [DATA_W-1:0] tx_data,
  output logic imem_we,
  output logic [IADDR_W-1:0] imem_addr,
  output logic [INST_W-1:0] imem_wdata,
  output logic cpu_reset,
  output logic cpu_en,
  input  logic halt_in,
  output logic [SEL_W-1:0] dump_sel,
  input  logic [DUMP_W-1:0] dump_data,
  output logic busy
);
  localparam int NB = INST_W / DATA_W;
  localparam int ND = DUMP_W / DATA_W;
  localparam int BW = NB > 1 ? $clog2(NB) : 1;
  localparam int DW = ND > 1 ? $clog2(ND) : 1;
  typedef enum logic [3:0] {IDLE, PROG, WRITE, WAIT_CMD, RUN, STEP, STEP_EN, SEND_SEL, SEND_TX, SEND_WAIT} state_t;
  state_t state, next;
  logic rx_prev, tx_prev, origin;
  logic [BW-1:0] pcnt;
  logic [DW-1:0] dcnt;
  logic [INST_W-1:0] word;
  logic [DUMP_W-1:0] shift;
  wire rx_ev = rx_done_tick & ~rx_prev;
  wire tx_ev = tx_done_tick & ~tx_prev;
  wire is_cmd = state == WAIT_CMD || state == STEP;
  assign busy = state != IDLE && state != WAIT_CMD;
  assign cpu_reset = state == IDLE || state == PROG || state == WRITE || state == WAIT_CMD;
  assign cpu_en = state == RUN || state == STEP_EN;
  assign tx_start = state == SEND_TX;
  assign tx_data = shift[DATA_W-1:0];
  assign imem_we = state == WRITE;
  assign imem_wdata = word;
  // state register
  always_ff @(posedge clk)
    state <= reset ? IDLE : next;
  // next-state: commands only matter in command states, TX events only while sending
  always_comb begin
    next = state;
    case (state)
      IDLE: next = rx_ev && rx_data == DATA_W'(1) ? PROG : IDLE;
      PROG: next = rx_ev && pcnt == BW'(NB - 1) ? WRITE : PROG;
      WRITE: next = word[INST_W-1 -: 6] == HALT_OP || &imem_addr ? WAIT_CMD : PROG;
      WAIT_CMD: next = !rx_ev ? WAIT_CMD : rx_data == DATA_W'(2) ? RUN : rx_data == DATA_W'(3) ? STEP :
                       rx_data == DATA_W'(5) ? IDLE : WAIT_CMD;
      RUN: next = halt_in ? SEND_SEL : RUN;
      STEP: next = !rx_ev ? STEP : rx_data == DATA_W'(6) ? STEP_EN : rx_data == DATA_W'(5) ? IDLE : STEP;
      STEP_EN: next = SEND_SEL;
      SEND_SEL: next = SEND_TX;
      SEND_TX: next = SEND_WAIT;
      SEND_WAIT: next = !tx_ev ? SEND_WAIT : dcnt != DW'(ND - 1) ? SEND_TX :
                        dump_sel != SEL_W'(DUMP_WORDS - 1) ? SEND_SEL : origin && !halt_in ? STEP : WAIT_CMD;
      default: next = IDLE;
    endcase
    next = is_cmd || state == IDLE || state == PROG ? next : next;
  end
  // datapath: tick edge detect, word assembly, write address, dump shifting
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_prev <= 1'b0;
      tx_prev <= 1'b0;
      origin <= 1'b0;
      pcnt <= '0;
      dcnt <= '0;
      word <= '0;
      shift <= '0;
      imem_addr <= '0;
      dump_sel <= '0;
    end else begin
      rx_prev <= rx_done_tick;
      tx_prev <= tx_done_tick;
      case (state)
        IDLE: begin
          imem_addr <= '0;
          pcnt <= '0;
        end
        PROG: if (rx_ev) begin
          word <= INST_W'({rx_data, word} >> DATA_W);
          pcnt <= pcnt + 1'b1;
        end
        WRITE: begin
          pcnt <= '0;
          if (!(&imem_addr)) imem_addr <= imem_addr + 1'b1;
        end
        RUN: begin
          origin <= 1'b0;
          dump_sel <= '0;
        end
        STEP_EN: begin
          origin <= 1'b1;
          dump_sel <= '0;
        end
        SEND_SEL: begin
          shift <= dump_data;
          dcnt <= '0;
        end
        SEND_WAIT: if (tx_ev) begin
          if (dcnt != DW'(ND - 1)) begin
            shift <= shift >> DATA_W;
            dcnt <= dcnt + 1'b1;
          end else dump_sel <= dump_sel + 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mips_debug_ctrl.sv
// tb_mips_debug_ctrl: scoreboard bench for the debug controller (program, run, step, held ticks, address full, reset mid-send)
module tb_mips_debug_ctrl;
  logic clk = 0, reset = 1, rx_done_tick = 0, tx_done_tick = 0, halt_in = 0;
  logic [7:0] rx_data = 0;
  logic tx_start, imem_we, cpu_reset, cpu_en, busy;
  logic [7:0] tx_data;
  logic [1:0] imem_addr, dump_sel;
  logic [31:0] imem_wdata, dump_data;
  typedef struct {logic [1:0] a; logic [31:0] d;} wr_t;
  typedef struct {logic [1:0] s; logic [7:0] b;} tx_t;
  wr_t wq[$];
  tx_t tq[$];
  int tests = 0, fails = 0, wr_cnt = 0, en_cnt = 0, tx_seen = 0, pend = 0, tx_hold = 1;
  logic prev_ts = 0;

  mips_debug_ctrl #(.IADDR_W(2)) dut (
    .clk(clk), .reset(reset), .rx_done_tick(rx_done_tick), .rx_data(rx_data),
    .tx_done_tick(tx_done_tick), .tx_start(tx_start), .tx_data(tx_data),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_reset(cpu_reset), .cpu_en(cpu_en), .halt_in(halt_in),
    .dump_sel(dump_sel), .dump_data(dump_data), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] dump_val(input logic [1:0] s);
    return s == 0 ? 32'h00000010 : {4'hA, 2'b0, s, 4'hB, 2'b0, s, 4'hC, 2'b0, s, 4'hD, 2'b0, s};
  endfunction
  assign dump_data = dump_val(dump_sel);

  // write scoreboard
  always @(negedge clk) if (imem_we) begin
    wr_t e;
    wr_cnt++;
    tests++;
    if (wq.size() == 0) begin
      fails++;
      $display("FAIL write_unexpected: addr=%0d data=%h, none required", imem_addr, imem_wdata);
    end else begin
      e = wq.pop_front();
      if (imem_addr !== e.a || imem_wdata !== e.d) begin
        fails++;
        $display("FAIL write: got %0d/%h, required %0d/%h", imem_addr, imem_wdata, e.a, e.d);
      end
    end
  end

  // tx scoreboard, single-cycle tx_start check and cpu_en cycle counter
  always @(negedge clk) begin
    if (cpu_en) en_cnt++;
    if (tx_start && prev_ts) begin
      tests++;
      fails++;
      $display("FAIL tx_start_width: high on two consecutive cycles, required one");
    end
    if (tx_start) begin
      tx_t e;
      tx_seen++;
      pend++;
      tests++;
      if (tq.size() == 0) begin
        fails++;
        $display("FAIL tx_unexpected: byte %h, none required", tx_data);
      end else begin
        e = tq.pop_front();
        if (tx_data !== e.b || dump_sel !== e.s) begin
          fails++;
          $display("FAIL tx_byte: got %h sel %0d, required %h sel %0d", tx_data, dump_sel, e.b, e.s);
        end
      end
    end
    prev_ts <= tx_start;
  end

  // UART TX model: acknowledge each started byte after a short delay
  always begin
    @(negedge clk);
    if (pend > 0) begin
      pend--;
      repeat (2) @(negedge clk);
      tx_done_tick = 1;
      repeat (tx_hold) @(negedge clk);
      tx_done_tick = 0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b, input int hold);
    @(negedge clk);
    rx_data = b;
    rx_done_tick = 1;
    repeat (hold) @(negedge clk);
    rx_done_tick = 0;
  endtask

  task automatic send_word(input logic [1:0] a, input logic [31:0] w, input int hold, input bit expect_wr);
    if (expect_wr) wq.push_back('{a, w});
    for (int b = 0; b < 4; b++) send_byte(w[8*b +: 8], hold);
  endtask

  task automatic push_dump();
    logic [31:0] v;
    for (int w = 0; w < 4; w++) begin
      v = dump_val(2'(w));
      for (int b = 0; b < 4; b++) tq.push_back('{2'(w), v[8*b +: 8]});
    end
  endtask

  task automatic wait_drain(input string nm);
    int i;
    for (i = 0; i < 3000 && tq.size() > 0; i++) @(negedge clk);
    tests++;
    if (tq.size() > 0) begin
      fails++;
      $display("FAIL %s_drain: %0d bytes still pending, required 0", nm, tq.size());
    end
    repeat (10) @(negedge clk);
  endtask

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] req);
    tests++;
    if (got !== req) begin
      fails++;
      $display("FAIL %s: got %h, required %h", nm, got, req);
    end
  endtask

  task automatic test_reset();
    reset = 1;
    repeat (3) @(negedge clk);
    check("rst_cpu_reset", cpu_reset, 1);
    check("rst_cpu_en", cpu_en, 0);
    check("rst_tx_start", tx_start, 0);
    check("rst_imem_we", imem_we, 0);
    check("rst_busy", busy, 0);
    check("rst_imem_addr", imem_addr, 0);
    check("rst_dump_sel", dump_sel, 0);
    check("rst_tx_data", tx_data, 0);
    reset = 0;
    @(negedge clk);
  endtask

  task automatic test_program();
    wr_cnt = 0;
    send_byte(8'h01, 1);
    send_word(0, 32'h44332211, 1, 1);
    send_word(1, 32'hDDCCBBAA, 1, 1);
    send_word(2, 32'hFC000000, 1, 1);
    repeat (4) @(negedge clk);
    check("prog_writes", wr_cnt, 3);
    check("prog_pending", wq.size(), 0);
    check("prog_busy", busy, 0);
    check("prog_cpu_reset", cpu_reset, 1);
  endtask

  task automatic test_run();
    en_cnt = 0;
    push_dump();
    send_byte(8'h02, 1);
    check("run_cpu_reset", cpu_reset, 0);
    repeat (19) @(negedge clk);
    halt_in = 1;
    @(negedge clk);
    halt_in = 0;
    wait_drain("run");
    check("run_en_cycles", en_cnt, 20);
    check("run_end_busy", busy, 0);
    check("run_end_cpu_reset", cpu_reset, 1);
  endtask

  task automatic test_step();
    send_byte(8'h03, 1);
    @(negedge clk);
    check("step_busy", busy, 1);
    check("step_cpu_reset", cpu_reset, 0);
    check("step_idle_en", cpu_en, 0);
    for (int k = 0; k < 3; k++) begin
      en_cnt = 0;
      push_dump();
      send_byte(8'h06, 1);
      wait_drain("step");
      check("step_en_pulse", en_cnt, 1);
      check("step_back_busy", busy, 1);
      check("step_back_cpu_reset", cpu_reset, 0);
    end
    send_byte(8'h05, 1);
    @(negedge clk);
    check("step_reprog_busy", busy, 0);
  endtask

  task automatic test_held_ticks();
    wr_cnt = 0;
    send_byte(8'h01, 5);
    send_word(0, 32'hFF030201, 5, 1);
    repeat (4) @(negedge clk);
    check("held_writes", wr_cnt, 1);
    check("held_busy", busy, 0);
    tx_hold = 3;
    en_cnt = 0;
    push_dump();
    send_byte(8'h02, 1);
    halt_in = 1;
    @(negedge clk);
    halt_in = 0;
    wait_drain("held_tx");
    check("held_en_cycles", en_cnt, 1);
    check("held_end_busy", busy, 0);
    tx_hold = 1;
  endtask

  task automatic test_addr_full();
    wr_cnt = 0;
    send_byte(8'h05, 1);
    send_byte(8'h01, 1);
    for (int i = 0; i < 5; i++) send_word(2'(i), 32'h13121110 + 32'h40404040 * i, 1, i < 4);
    repeat (4) @(negedge clk);
    check("full_writes", wr_cnt, 4);
    check("full_addr", imem_addr, 3);
    check("full_busy", busy, 0);
    check("full_cpu_reset", cpu_reset, 1);
  endtask

  task automatic test_reset_send();
    int base, i;
    push_dump();
    base = tx_seen;
    send_byte(8'h02, 1);
    halt_in = 1;
    @(negedge clk);
    halt_in = 0;
    for (i = 0; i < 500 && tx_seen - base < 5; i++) @(negedge clk);
    check("rsend_reached", tx_seen - base, 5);
    reset = 1;
    tq.delete();
    pend = 0;
    @(negedge clk);
    check("rsend_tx_start", tx_start, 0);
    check("rsend_cpu_reset", cpu_reset, 1);
    check("rsend_imem_addr", imem_addr, 0);
    check("rsend_busy", busy, 0);
    check("rsend_cpu_en", cpu_en, 0);
    reset = 0;
    repeat (8) @(negedge clk);
    wr_cnt = 0;
    send_byte(8'h01, 1);
    send_word(0, 32'hFC000000, 1, 1);
    repeat (4) @(negedge clk);
    check("rsend_reprog_writes", wr_cnt, 1);
    check("rsend_reprog_pending", wq.size(), 0);
  endtask

  initial begin
    test_reset();
    test_program();
    test_run();
    test_step();
    test_held_ticks();
    test_addr_full();
    test_reset_send();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
